// File: rtl/tl_mem_responder.sv
// tl_mem_responder: TileLink-C manager endpoint backed by a one-beat 512-bit line memory; never probes.
// Optional protocol checker enabled by defining TL_RESPONDER_CHECK_EN (drives sticky err_o).
package tl_pkg;
  typedef struct packed {
    logic [2:0]   opcode;
    logic [2:0]   param;
    logic [3:0]   size;
    logic [3:0]   source;
    logic [31:0]  address;
    logic [63:0]  mask;
    logic [511:0] data;
  } TLreqApacked_t;
  typedef TLreqApacked_t TLreqBpacked_t;
  typedef struct packed {
    logic [2:0]   opcode;
    logic [2:0]   param;
    logic [3:0]   size;
    logic [3:0]   source;
    logic [31:0]  address;
    logic [511:0] data;
  } TLreqCpacked_t;
  typedef struct packed {
    logic [2:0]   opcode;
    logic [1:0]   param;
    logic [3:0]   size;
    logic [3:0]   source;
    logic [1:0]   sink;
    logic         denied;
    logic         corrupt;
    logic [511:0] data;
  } TLreqDpacked_t;
  typedef struct packed {
    logic [1:0] sink;
  } TLreqEpacked_t;
endpackage

module tl_mem_responder
  import tl_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
  parameter int          LINES     = 1024,
  parameter logic [1:0]  SINK_ID   = 2'd0
) (
  input  logic          clock_i,
  input  logic          reset_i,
  output logic          a_ready_o,
  input  logic          a_valid_i,
  input  TLreqApacked_t a_beat_i,
  input  logic          b_ready_i,
  output logic          b_valid_o,
  output TLreqBpacked_t b_beat_o,
  output logic          c_ready_o,
  input  logic          c_valid_i,
  input  TLreqCpacked_t c_beat_i,
  input  logic          d_ready_i,
  output logic          d_valid_o,
  output TLreqDpacked_t d_beat_o,
  output logic          e_ready_o,
  input  logic          e_valid_i,
  input  TLreqEpacked_t e_beat_i,
  output logic          err_o
);
  localparam int LW = $clog2(LINES);
  localparam logic [1:0] IDLE = 2'd0, RESP = 2'd1, WAIT_E = 2'd2;
  logic [1:0]    state;
  logic [511:0]  mem [LINES];
  logic          sel_c, c_fire, a_fire, fire, in_range, a_legal, c_legal, ok, data_resp, we, grant;
  logic [31:0]   addr, off;
  logic [LW-1:0] idx;
  logic [511:0]  bit_mask, wdata;
  TLreqDpacked_t resp;
  logic          unused_ok;
  assign b_valid_o = 1'b0;
  assign b_beat_o  = '0;
  assign c_ready_o = state == IDLE && !reset_i;
  assign a_ready_o = c_ready_o && !c_valid_i;
  assign e_ready_o = state == WAIT_E && !reset_i;
  assign d_valid_o = state == RESP;
  assign c_fire    = c_valid_i && c_ready_o;
  assign a_fire    = a_valid_i && a_ready_o;
  assign fire      = c_fire || a_fire;
  // C always wins arbitration, so a pending C selects the datapath
  assign sel_c     = c_valid_i;
  assign addr      = sel_c ? c_beat_i.address : a_beat_i.address;
  assign off       = addr - BASE_ADDR;
  assign in_range  = addr >= BASE_ADDR && off[31:6] < 26'(LINES);
  assign idx       = off[6 +: LW];
  assign a_legal   = a_beat_i.opcode inside {3'd0, 3'd1, 3'd4, 3'd6, 3'd7};
  assign c_legal   = c_beat_i.opcode inside {3'd6, 3'd7};
  assign ok        = in_range && (sel_c ? c_legal : a_legal);
  assign data_resp = !sel_c && a_beat_i.opcode inside {3'd2, 3'd3, 3'd4, 3'd6};
  assign we        = fire && ok && (sel_c ? c_beat_i.opcode == 3'd7 : a_beat_i.opcode[2:1] == 2'b00);
  assign wdata     = sel_c ? c_beat_i.data : a_beat_i.data;
  assign grant     = d_beat_o.opcode[2:1] == 2'b10;
  assign unused_ok = ^{b_ready_i, a_beat_i.param, c_beat_i.param, off[5:0], e_beat_i};
  for (genvar g = 0; g < 64; g++) begin : g_mask
    assign bit_mask[8*g +: 8] = {8{sel_c || a_beat_i.opcode == 3'd0 || a_beat_i.mask[g]}};
  end
  always_comb begin
    resp         = '0;
    resp.size    = sel_c ? c_beat_i.size : a_beat_i.size;
    resp.source  = sel_c ? c_beat_i.source : a_beat_i.source;
    resp.denied  = !ok;
    resp.opcode  = sel_c ? 3'd6 :
                   !ok ? {2'b00, data_resp} :
                   a_beat_i.opcode == 3'd4 ? 3'd1 :
                   a_beat_i.opcode == 3'd6 ? 3'd5 :
                   a_beat_i.opcode == 3'd7 ? 3'd4 : 3'd0;
    resp.sink    = resp.opcode[2:1] == 2'b10 ? SINK_ID : 2'd0;
    resp.corrupt = data_resp && !ok;
    resp.data    = data_resp && ok ? mem[idx] : '0;
  end
  always_ff @(posedge clock_i) begin
    if (we) mem[idx] <= (mem[idx] & ~bit_mask) | (wdata & bit_mask);
  end
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state    <= IDLE;
      d_beat_o <= '0;
    end else begin
      state <= state == IDLE ? (fire ? RESP : IDLE) :
               state == RESP ? (d_ready_i ? (grant ? WAIT_E : IDLE) : RESP) :
               state == WAIT_E ? (e_valid_i ? IDLE : WAIT_E) : IDLE;
      if (fire) d_beat_o <= resp;
    end
  end
`ifdef TL_RESPONDER_CHECK_EN
  logic          stall_q;
  TLreqDpacked_t beat_q;
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      err_o   <= 1'b0;
      stall_q <= 1'b0;
      beat_q  <= '0;
    end else begin
      stall_q <= d_valid_o && !d_ready_i;
      beat_q  <= d_beat_o;
      if ((e_valid_i && state != WAIT_E) || (e_valid_i && e_ready_o && e_beat_i.sink != SINK_ID) ||
          (fire && !ok) || (stall_q && d_beat_o != beat_q)) err_o <= 1'b1;
    end
  end
`else
  assign err_o = 1'b0;
`endif
endmodule

// File: tb/tb_tl_mem_responder.sv
// tb_tl_mem_responder: randomized self-checking bench for tl_mem_responder against a line-memory reference model.
module tb_tl_mem_responder;
  import tl_pkg::*;
  localparam logic [31:0] BASE = 32'h8000_0000;
  localparam int LINES = 1024;
  logic clk = 1'b0, rst = 1'b1;
  logic a_ready, a_valid = 1'b0, b_valid, c_ready, c_valid = 1'b0;
  logic d_ready = 1'b0, d_valid, e_ready, e_valid = 1'b0, err;
  TLreqApacked_t a_beat = '0;
  TLreqBpacked_t b_beat;
  TLreqCpacked_t c_beat = '0;
  TLreqDpacked_t d_beat;
  TLreqEpacked_t e_beat = '0;
  int checks = 0, errors = 0;
  logic [511:0] ref_mem [int];
  always #5 clk = ~clk;
  tl_mem_responder dut (
    .clock_i(clk), .reset_i(rst),
    .a_ready_o(a_ready), .a_valid_i(a_valid), .a_beat_i(a_beat),
    .b_ready_i(1'b1), .b_valid_o(b_valid), .b_beat_o(b_beat),
    .c_ready_o(c_ready), .c_valid_i(c_valid), .c_beat_i(c_beat),
    .d_ready_i(d_ready), .d_valid_o(d_valid), .d_beat_o(d_beat),
    .e_ready_o(e_ready), .e_valid_i(e_valid), .e_beat_i(e_beat),
    .err_o(err)
  );
  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  function automatic logic [511:0] rnd512();
    logic [511:0] v;
    for (int i = 0; i < 16; i++) v[32*i +: 32] = $urandom;
    return v;
  endfunction
  function automatic TLreqApacked_t mk_a(logic [2:0] op, logic [31:0] ad, logic [3:0] src, logic [63:0] m, logic [511:0] dt);
    TLreqApacked_t b;
    b = '0;
    b.opcode = op; b.size = 4'd6; b.source = src; b.address = ad; b.mask = m; b.data = dt;
    return b;
  endfunction
  // Expected D beat for an A request; applies any write to the reference memory
  function automatic TLreqDpacked_t model_a(TLreqApacked_t a);
    TLreqDpacked_t d;
    longint unsigned ad, hi;
    bit inr;
    int line;
    logic [511:0] v;
    ad = a.address;
    hi = longint'(BASE) + 64 * LINES;
    inr = ad >= BASE && ad < hi;
    line = inr ? int'((ad - BASE) / 64) : -1;
    v = ref_mem.exists(line) ? ref_mem[line] : '0;
    d = '0;
    d.size = a.size;
    d.source = a.source;
    case (a.opcode)
      3'd0: if (inr) ref_mem[line] = a.data; else d.denied = 1'b1;
      3'd1: if (inr) begin
              for (int b = 0; b < 64; b++) if (a.mask[b]) v[8*b +: 8] = a.data[8*b +: 8];
              ref_mem[line] = v;
            end else d.denied = 1'b1;
      3'd4: begin
              d.opcode = 3'd1;
              if (inr) d.data = v; else begin d.denied = 1'b1; d.corrupt = 1'b1; end
            end
      3'd6: if (inr) begin d.opcode = 3'd5; d.data = v; end
            else begin d.opcode = 3'd1; d.denied = 1'b1; d.corrupt = 1'b1; end
      3'd7: if (inr) d.opcode = 3'd4; else d.denied = 1'b1;
      default: d.denied = 1'b1;
    endcase
    return d;
  endfunction
  task automatic send_a(input TLreqApacked_t b);
    int n = 0;
    @(negedge clk);
    a_valid = 1'b1;
    a_beat = b;
    #1;
    while (!a_ready && n < 50) begin @(negedge clk); n++; end
    checks++;
    if (!a_ready) begin errors++; $display("FAIL a_accept_timeout a_ready=%b required 1", a_ready); end
    @(posedge clk);
    #1 a_valid = 1'b0;
  endtask
  task automatic wait_d(output TLreqDpacked_t d, output int lat);
    lat = 0;
    @(negedge clk);
    while (!d_valid && lat < 50) begin @(negedge clk); lat++; end
    checks++;
    if (!d_valid) begin errors++; $display("FAIL d_timeout d_valid=%b required 1", d_valid); end
    d = d_beat;
    d_ready = 1'b1;
    @(posedge clk);
    #1 d_ready = 1'b0;
  endtask
  task automatic do_a(input TLreqApacked_t b, output TLreqDpacked_t d);
    int lat;
    send_a(b);
    wait_d(d, lat);
  endtask
  task automatic test_reset();
    #2;
    checks++;
    if ({a_ready, c_ready, e_ready, d_valid, err, b_valid} !== 6'b0 || d_beat !== '0) begin
      errors++;
      $display("FAIL reset_outputs got a%b c%b e%b d%b err%b b%b beat=%h required all 0", a_ready, c_ready, e_ready, d_valid, err, b_valid, d_beat);
    end
    @(negedge clk) rst = 1'b0;
    @(negedge clk);
    checks++;
    if (a_ready !== 1'b1 || c_ready !== 1'b1 || e_ready !== 1'b0) begin
      errors++; $display("FAIL idle_readies got a%b c%b e%b required 1 1 0", a_ready, c_ready, e_ready);
    end
  endtask
  task automatic test_put_get();
    TLreqApacked_t b;
    TLreqDpacked_t d, exp;
    int lat;
    b = mk_a(3'd0, 32'h8000_0040, 4'd3, '1, {64{8'hAA}});
    exp = model_a(b);
    do_a(b, d);
    checks++;
    if (d !== exp || d.opcode !== 3'd0) begin errors++; $display("FAIL put_ack got %h required %h", d, exp); end
    b = mk_a(3'd4, 32'h8000_0040, 4'd5, '0, '0);
    exp = model_a(b);
    send_a(b);
    wait_d(d, lat);
    checks++;
    if (lat !== 0) begin errors++; $display("FAIL get_latency got %0d extra cycles required 0", lat); end
    checks++;
    if (d !== exp || d.data !== {64{8'hAA}} || d.source !== 4'd5) begin
      errors++; $display("FAIL get_data got %h required %h", d, exp);
    end
  endtask
  task automatic test_partial();
    TLreqApacked_t b;
    TLreqDpacked_t d, exp;
    logic [511:0] want;
    want = '0;
    want[31:0] = 32'hFFFF_FFFF;
    b = mk_a(3'd0, 32'h8000_0080, 4'd1, '1, '0);
    exp = model_a(b);
    do_a(b, d);
    b = mk_a(3'd1, 32'h8000_0080, 4'd2, 64'h0F, '1);
    exp = model_a(b);
    do_a(b, d);
    checks++;
    if (d !== exp) begin errors++; $display("FAIL partial_ack got %h required %h", d, exp); end
    b = mk_a(3'd4, 32'h8000_0080, 4'd2, '0, '0);
    exp = model_a(b);
    do_a(b, d);
    checks++;
    if (d !== exp || d.data !== want) begin errors++; $display("FAIL partial_get got %h required %h", d.data, want); end
  endtask
  task automatic test_out_of_range();
    TLreqApacked_t b;
    TLreqDpacked_t d, exp;
    checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL err_before_oor got %b required 0", err); end
    b = mk_a(3'd4, 32'h7FFF_FFC0, 4'd6, '0, '0);
    exp = model_a(b);
    do_a(b, d);
    checks++;
    if (d !== exp || d.denied !== 1'b1 || d.corrupt !== 1'b1 || d.data !== '0) begin
      errors++; $display("FAIL oor_get got %h required %h", d, exp);
    end
    checks++;
`ifdef TL_RESPONDER_CHECK_EN
    if (err !== 1'b1) begin errors++; $display("FAIL oor_err got %b required 1", err); end
`else
    if (err !== 1'b0) begin errors++; $display("FAIL oor_err got %b required 0", err); end
`endif
  endtask
  task automatic test_c_priority();
    TLreqApacked_t g;
    TLreqDpacked_t d, exp, expc;
    logic [511:0] cd;
    int lat, n;
    cd = rnd512();
    g = mk_a(3'd4, 32'h8000_00C0, 4'd9, '0, '0);
    @(negedge clk);
    c_beat = '0;
    c_beat.opcode = 3'd7; c_beat.size = 4'd6; c_beat.source = 4'd4; c_beat.address = 32'h8000_00C0; c_beat.data = cd;
    c_valid = 1'b1;
    a_beat = g;
    a_valid = 1'b1;
    #1;
    checks++;
    if (a_ready !== 1'b0 || c_ready !== 1'b1) begin errors++; $display("FAIL c_over_a got a%b c%b required 0 1", a_ready, c_ready); end
    @(posedge clk);
    #1 c_valid = 1'b0;
    ref_mem[3] = cd;
    expc = '0;
    expc.opcode = 3'd6; expc.size = 4'd6; expc.source = 4'd4;
    wait_d(d, lat);
    checks++;
    if (d !== expc) begin errors++; $display("FAIL release_ack got %h required %h", d, expc); end
    n = 0;
    @(negedge clk);
    while (!a_ready && n < 20) begin @(negedge clk); n++; end
    exp = model_a(g);
    @(posedge clk);
    #1 a_valid = 1'b0;
    wait_d(d, lat);
    checks++;
    if (d !== exp || d.data !== cd) begin errors++; $display("FAIL a_after_c got %h required %h", d, exp); end
  endtask
  task automatic test_stall();
    TLreqApacked_t b;
    TLreqDpacked_t exp, snap;
    b = mk_a(3'd4, 32'h8000_0040, 4'd7, '0, '0);
    exp = model_a(b);
    send_a(b);
    @(negedge clk);
    snap = d_beat;
    checks++;
    if (d_valid !== 1'b1 || snap !== exp) begin errors++; $display("FAIL stall_first got v%b %h required %h", d_valid, snap, exp); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (d_valid !== 1'b1 || d_beat !== snap) begin errors++; $display("FAIL stall_hold cycle %0d v%b %h required %h", i, d_valid, d_beat, snap); end
    end
    d_ready = 1'b1;
    @(posedge clk);
    #1 d_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (d_valid !== 1'b0) begin errors++; $display("FAIL stall_release d_valid=%b required 0", d_valid); end
  endtask
  task automatic test_acquire();
    TLreqApacked_t b, g;
    TLreqDpacked_t d, exp;
    int lat;
    b = mk_a(3'd6, 32'h8000_0040, 4'd1, '0, '0);
    exp = model_a(b);
    do_a(b, d);
    checks++;
    if (d !== exp || d.opcode !== 3'd5 || d.param !== 2'd0 || d.sink !== 2'd0) begin
      errors++; $display("FAIL grant_data got %h required %h", d, exp);
    end
    g = mk_a(3'd4, 32'h8000_0040, 4'd2, '0, '0);
    a_beat = g;
    a_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (a_ready !== 1'b0 || c_ready !== 1'b0 || e_ready !== 1'b1) begin
        errors++; $display("FAIL wait_e_block got a%b c%b e%b required 0 0 1", a_ready, c_ready, e_ready);
      end
    end
    e_beat.sink = 2'd1;
    e_valid = 1'b1;
    @(posedge clk);
    #1 e_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (a_ready !== 1'b1) begin errors++; $display("FAIL after_grantack a_ready=%b required 1", a_ready); end
    exp = model_a(g);
    @(posedge clk);
    #1 a_valid = 1'b0;
    wait_d(d, lat);
    checks++;
    if (d !== exp) begin errors++; $display("FAIL get_after_e got %h required %h", d, exp); end
  endtask
  task automatic test_random();
    TLreqApacked_t b;
    TLreqDpacked_t d, exp;
    int k, line;
    logic [31:0] ad;
    logic [2:0] op;
    for (int i = 0; i < 8; i++) begin
      b = mk_a(3'd0, BASE + 32'(64 * i), 4'(i), '1, rnd512());
      exp = model_a(b);
      do_a(b, d);
    end
    for (int i = 0; i < 40; i++) begin
      k = $urandom_range(0, 3);
      line = $urandom_range(0, 7);
      ad = BASE + 32'(64 * line);
      op = k == 0 ? 3'd0 : k == 1 ? 3'd1 : 3'd4;
      if (k == 3) begin
        ad = $urandom_range(0, 1) ? BASE - 32'(64 * (line + 1)) : BASE + 32'(64 * LINES + 64 * line);
        op = $urandom_range(0, 1) ? 3'd4 : 3'd0;
      end
      b = mk_a(op, ad, 4'($urandom), {$urandom, $urandom}, rnd512());
      exp = model_a(b);
      do_a(b, d);
      checks++;
      if (d !== exp) begin errors++; $display("FAIL random_%0d op%0d addr %h got %h required %h", i, op, ad, d, exp); end
    end
  endtask
  task automatic test_reset_wait_e();
    TLreqApacked_t b;
    TLreqDpacked_t d, exp;
    b = mk_a(3'd7, 32'h8000_0100, 4'd3, '0, '0);
    exp = model_a(b);
    do_a(b, d);
    checks++;
    if (d !== exp || d.opcode !== 3'd4) begin errors++; $display("FAIL grant got %h required %h", d, exp); end
    @(negedge clk);
    checks++;
    if (e_ready !== 1'b1 || d_valid !== 1'b0) begin errors++; $display("FAIL in_wait_e got e%b d%b required 1 0", e_ready, d_valid); end
    rst = 1'b1;
    #1;
    checks++;
    if (d_valid !== 1'b0 || e_ready !== 1'b0 || a_ready !== 1'b0 || err !== 1'b0 || d_beat !== '0) begin
      errors++; $display("FAIL mid_reset got d%b e%b a%b err%b beat %h required all 0", d_valid, e_ready, a_ready, err, d_beat);
    end
    @(negedge clk) rst = 1'b0;
    @(negedge clk);
    checks++;
    if (a_ready !== 1'b1 || e_ready !== 1'b0) begin errors++; $display("FAIL post_reset_idle got a%b e%b required 1 0", a_ready, e_ready); end
  endtask
  initial begin
    test_reset();
    test_put_get();
    test_partial();
    test_out_of_range();
    test_c_priority();
    test_stall();
    test_acquire();
    test_random();
    test_reset_wait_e();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
